spi_flash_reader: RTL
=====================

# spi_flash_reader

SPI NOR flash read sequencer that sits directly upstream of the `spi` master peripheral. It drives the `spi` block's register-write port and watches its `spi_ctrl`/`spi_data`/`spi_status` outputs. For each read it issues command 0x03 plus a 24-bit address, then clocks out N data bytes and delivers them on a valid/ready byte stream. Flash boot-copy and loader logic use it, so the CPU never polls SPI.

## Interface
- `SPI_CTRL`, 8'h20, control register offset driven on `addr_o[7:0]`
- `SPI_DATA`, 8'h24, data register offset
- `SPI_STATUS`, 8'h28, status register offset (decoded by the `spi` block; not written)
- `CLK_DIV`, 8'd0, value placed in ctrl[15:8] (0 = clk/2)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `start_i`  in  1  one-cycle request; sampled only in IDLE
- `flash_addr_i`  in  24  flash byte address, latched on start
- `len_i`  in  16  data bytes to read, latched on start; 0 = command/address only
- `busy_o`  out  1  high from the cycle after accepted start through DONE
- `done_o`  out  1  one-cycle pulse at end of operation
- `rd_data_o`  out  8  received byte
- `rd_valid_o`  out  1  byte valid; held until `rd_ready_i`
- `rd_ready_i`  in  1  consumer accepts byte when valid & ready
- `data_o`  out  32  write data to `spi`
- `addr_o`  out  32  {24'h0, offset}
- `sel_o`  out  4  always 4'b1111 when `req_valid_o`, else 0
- `we_o`  out  1  equals `req_valid_o`
- `req_valid_o`  out  1  one-cycle write strobe
- `spi_ctrl_i`, `spi_data_i`, `spi_status_i`  in  32 each  `spi` register outputs

## Operation
- All outputs are registered. Every bus write is a single cycle: `req_valid_o`=`we_o`=1 with stable `addr_o`/`data_o`. `req_valid_o` is 0 in every other cycle.
- SPI mode 0 (CPOL=0, CPHA=0). Let SEL = {16'h0, CLK_DIV, 8'h08} and GO = SEL | 1.
- States:
  - IDLE: on `start_i`, latch the address and length, clear byte index `idx` (3 bits, saturating at 4), go to CS_ON.
  - CS_ON: write ctrl = SEL, go to LOAD.
  - LOAD: write data. The byte is 0x03 when idx=0, A[23:16] when 1, A[15:8] when 2, A[7:0] when 3, and 0x00 when idx=4 (dummy byte for a read). Go to GO.
  - GO: write ctrl = GO, go to WAIT_HI.
  - WAIT_HI: wait until `spi_status_i[0]`=1, then go to WAIT_LO.
  - WAIT_LO: wait until `spi_status_i[0]`=0.
    - If idx<3: idx++, go to LOAD.
    - If idx=3: idx=4. Go to CS_OFF if remaining length is 0, else LOAD.
    - If idx=4: capture `spi_data_i[7:0]` into `rd_data_o`, go to OUT.
  - OUT: `rd_valid_o`=1 until `rd_ready_i`. On handshake, drop valid and decrement remaining. Go to CS_OFF if remaining is 0, else LOAD.
  - CS_OFF: write ctrl = {16'h0, CLK_DIV, 8'h00} to deassert SS, go to DONE.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- Backpressure stalls in OUT with no bus activity. SS stays asserted; flash reads tolerate a stalled clock.
- `start_i` outside IDLE is ignored, including during DONE.
- `len_i`=0xFFFF reads 65535 bytes. The remaining counter is 16-bit and never wraps.

## Timing
- Reset (async assert, deassert sync to `clk`): state IDLE. `busy_o`, `done_o`, `rd_valid_o`, `req_valid_o`, `we_o` are 0. `rd_data_o`, `data_o`, `addr_o`, `sel_o` are 0.
- Reset mid-operation aborts immediately with no CS_OFF write. The `spi` block shares `rst`, so SS also releases.
- `start_i` high in cycle 0 gives `busy_o`=1 in cycle 1 and the CS_ON write in cycle 1. The first LOAD write is in cycle 2 and the first GO write in cycle 3.
- WAIT_HI is required because `spi_status[0]` rises 2 cycles after the GO write. Polling idle earlier would finish the byte falsely.
- `spi_data_i` holds the received byte once `spi_status_i[0]` falls. It is sampled in the same cycle WAIT_LO sees 0.
- `done_o` fires the cycle after the CS_OFF write. `busy_o` falls together with the DONE→IDLE transition.

## Test plan
All scenarios run against the real `spi` block plus a mode-0 flash model.
- Reset: hold `rst`=0 with random inputs -> all outputs 0, no `req_valid_o`. Release, idle 10 cycles -> still 0.
- start, addr 0x123456, len 2, flash returns 0xA5, 0x3C:
  - Bus writes in exactly this order: ctrl 0x08; then data/ctrl 0x09 pairs carrying data 0x03, 0x12, 0x34, 0x56, 0x00, 0x00; then ctrl 0x00.
  - Flash sees MOSI 03 12 34 56.
  - Stream yields A5 then 3C; `done_o` pulses once.
- len 0, addr 0xFFFFFF -> 4 byte transfers, no `rd_valid_o`, final ctrl 0x00, `done_o` pulse.
- Backpressure: hold `rd_ready_i` low 20 cycles on byte 1 -> `rd_valid_o` and `rd_data_o` stay stable, zero bus writes, SS stays low. After release, byte 2 proceeds.
- Pulse `start_i` in WAIT_LO and in DONE -> ignored, with a single `done_o` for the first operation.
- Assert `rst` during WAIT_LO of byte 3 -> outputs 0 asynchronously, no further writes. A new start with len 1 completes correctly.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// Byte-stream, control and spi register bus bundle for spi_flash_reader.
// master = the reader, slave = the environment (spi block + consumer).
interface spi_flash_reader_if;
  logic        start_i;
  logic [23:0] flash_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] data_o;
  logic [31:0] addr_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        req_valid_o;
  logic [31:0] spi_ctrl_i;
  logic [31:0] spi_data_i;
  logic [31:0] spi_status_i;

  modport master (
    input  start_i, flash_addr_i, len_i, rd_ready_i,
    input  spi_ctrl_i, spi_data_i, spi_status_i,
    output busy_o, done_o, rd_data_o, rd_valid_o,
    output data_o, addr_o, sel_o, we_o, req_valid_o
  );

  modport slave (
    output start_i, flash_addr_i, len_i, rd_ready_i,
    output spi_ctrl_i, spi_data_i, spi_status_i,
    input  busy_o, done_o, rd_data_o, rd_valid_o,
    input  data_o, addr_o, sel_o, we_o, req_valid_o
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI NOR read sequencer: drives the spi block's register port to issue
// 0x03 + 24-bit address, then streams N received bytes out.
module spi_flash_reader (
  input logic clk,
  input logic rst,
  spi_flash_reader_if.master b
);
  localparam logic [7:0]  SPI_CTRL = 8'h20;
  localparam logic [7:0]  SPI_DATA = 8'h24;
  localparam logic [7:0]  CLK_DIV  = 8'd0;
  localparam logic [31:0] SEL_W = {16'h0, CLK_DIV, 8'h08};
  localparam logic [31:0] GO_W  = SEL_W | 32'h1;
  localparam logic [31:0] OFF_W = {16'h0, CLK_DIV, 8'h00};

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_LOAD, S_GO, S_WAIT_HI,
    S_WAIT_LO, S_OUT, S_CS_OFF, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [23:0] fa, fa_n;
  logic [15:0] rem, rem_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  rdat_n;
  logic        req_n;
  logic [31:0] waddr_n, wdata_n;
  logic [7:0]  tx_byte;

  wire unused_bits = ^{b.spi_ctrl_i, b.spi_data_i[31:8],
                       b.spi_status_i[31:1]};

  always_comb begin
    state_n = state;
    fa_n    = fa;
    rem_n   = rem;
    idx_n   = idx;
    rdat_n  = b.rd_data_o;
    unique case (state)
      S_IDLE: begin
        if (b.start_i) begin
          fa_n    = b.flash_addr_i;
          rem_n   = b.len_i;
          idx_n   = 3'd0;
          state_n = S_CS_ON;
        end
      end
      S_CS_ON: state_n = S_LOAD;
      S_LOAD:  state_n = S_GO;
      S_GO:    state_n = S_WAIT_HI;
      S_WAIT_HI: begin
        if (b.spi_status_i[0]) state_n = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!b.spi_status_i[0]) begin
          if (idx < 3'd3) begin
            idx_n   = idx + 3'd1;
            state_n = S_LOAD;
          end else if (idx == 3'd3) begin
            idx_n   = 3'd4;
            state_n = (rem == 16'd0) ? S_CS_OFF : S_LOAD;
          end else begin
            rdat_n  = b.spi_data_i[7:0];
            state_n = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (b.rd_ready_i) begin
          rem_n   = (rem != 16'd0) ? rem - 16'd1 : rem;
          state_n = (rem <= 16'd1) ? S_CS_OFF : S_LOAD;
        end
      end
      S_CS_OFF: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    case (idx_n)
      3'd0:    tx_byte = 8'h03;
      3'd1:    tx_byte = fa_n[23:16];
      3'd2:    tx_byte = fa_n[15:8];
      3'd3:    tx_byte = fa_n[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the next state.
  always_comb begin
    req_n   = 1'b0;
    waddr_n = b.addr_o;
    wdata_n = b.data_o;
    unique case (1'b1)
      (state_n == S_CS_ON): begin
        req_n   = 1'b1;
        waddr_n = {24'h0, SPI_CTRL};
        wdata_n = SEL_W;
      end
      (state_n == S_LOAD): begin
        req_n   = 1'b1;
        waddr_n = {24'h0, SPI_DATA};
        wdata_n = {24'h0, tx_byte};
      end
      (state_n == S_GO): begin
        req_n   = 1'b1;
        waddr_n = {24'h0, SPI_CTRL};
        wdata_n = GO_W;
      end
      (state_n == S_CS_OFF): begin
        req_n   = 1'b1;
        waddr_n = {24'h0, SPI_CTRL};
        wdata_n = OFF_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      fa            <= 24'h0;
      rem           <= 16'h0;
      idx           <= 3'd0;
      b.busy_o      <= 1'b0;
      b.done_o      <= 1'b0;
      b.rd_data_o   <= 8'h0;
      b.rd_valid_o  <= 1'b0;
      b.req_valid_o <= 1'b0;
      b.we_o        <= 1'b0;
      b.sel_o       <= 4'h0;
      b.addr_o      <= 32'h0;
      b.data_o      <= 32'h0;
    end else begin
      state         <= state_n;
      fa            <= fa_n;
      rem           <= rem_n;
      idx           <= idx_n;
      b.busy_o      <= (state_n != S_IDLE);
      b.done_o      <= (state_n == S_DONE);
      b.rd_data_o   <= rdat_n;
      b.rd_valid_o  <= (state_n == S_OUT);
      b.req_valid_o <= req_n;
      b.we_o        <= req_n;
      b.sel_o       <= req_n ? 4'hF : 4'h0;
      b.addr_o      <= waddr_n;
      b.data_o      <= wdata_n;
    end
  end
endmodule
